// File: rtl/seq_alu_pkg.sv
// Shared opcode, flag-mode and FSM state definitions for the sequential ALU.
package seq_alu_pkg;

   localparam int unsigned OP_W = 4;
   localparam int unsigned ZC_W = 2;

   localparam logic [OP_W-1:0] OP_AND  = 4'b0000;
   localparam logic [OP_W-1:0] OP_OR   = 4'b0001;
   localparam logic [OP_W-1:0] OP_ADD  = 4'b0010;
   localparam logic [OP_W-1:0] OP_SLT  = 4'b0011;
   localparam logic [OP_W-1:0] OP_SLL  = 4'b0100;
   localparam logic [OP_W-1:0] OP_SRL  = 4'b0101;
   localparam logic [OP_W-1:0] OP_SUB  = 4'b0110;
   localparam logic [OP_W-1:0] OP_XOR  = 4'b0111;
   localparam logic [OP_W-1:0] OP_MULU = 4'b1000;
   localparam logic [OP_W-1:0] OP_DIVU = 4'b1001;
   localparam logic [OP_W-1:0] OP_NOR  = 4'b1100;
   localparam logic [OP_W-1:0] OP_SRA  = 4'b1101;
   localparam logic [OP_W-1:0] OP_FSUB = 4'b1110;

   localparam logic [ZC_W-1:0] ZC_EQ = 2'b00;
   localparam logic [ZC_W-1:0] ZC_NE = 2'b01;
   localparam logic [ZC_W-1:0] ZC_GT = 2'b10;
   localparam logic [ZC_W-1:0] ZC_GE = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bus of the sequential ALU: valid/ready in, valid/ready out.
interface seq_alu_if
   import seq_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [OP_W-1:0]  alu_op;
   logic [ZC_W-1:0]  zero_ctr;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] alu_out;
   logic [WIDTH-1:0] alu_hi;
   logic             zero;
   logic             div_zero;

   modport master (
      output in_valid, alu_a, alu_b, alu_op, zero_ctr, out_ready,
      input  in_ready, out_valid, alu_out, alu_hi, zero, div_zero
   );

   modport slave (
      input  in_valid, alu_a, alu_b, alu_op, zero_ctr, out_ready,
      output in_ready, out_valid, alu_out, alu_hi, zero, div_zero
   );
endinterface

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one bit per cycle.
// The first iteration runs on the start edge straight from the operands.
module seq_alu_muldiv #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0] hi_q, lo_q, b_q;
   logic             div_q, busy_q, done_q;
   logic [CNT_W-1:0] cnt_q;

   logic [WIDTH-1:0] cur_hi, cur_lo, cur_b, nxt_hi, nxt_lo;
   logic             cur_div;
   logic [WIDTH:0]   sum_c, shifted_c, diff_c;

   // One iteration: hi/lo hold product or remainder/quotient
   always_comb begin
      cur_hi    = start ? '0 : hi_q;
      cur_lo    = start ? a : lo_q;
      cur_b     = start ? b : b_q;
      cur_div   = start ? is_div : div_q;
      sum_c     = {1'b0, cur_hi} + {1'b0, cur_b};
      shifted_c = {cur_hi, cur_lo[WIDTH-1]};
      diff_c    = shifted_c - {1'b0, cur_b};
      nxt_hi    = cur_hi;
      nxt_lo    = cur_lo;
      if (cur_div) begin
         if (!diff_c[WIDTH]) begin
            nxt_hi = diff_c[WIDTH-1:0];
            nxt_lo = {cur_lo[WIDTH-2:0], 1'b1};
         end else begin
            nxt_hi = shifted_c[WIDTH-1:0];
            nxt_lo = {cur_lo[WIDTH-2:0], 1'b0};
         end
      end else if (cur_lo[0]) begin
         {nxt_hi, nxt_lo} = {sum_c, cur_lo[WIDTH-1:1]};
      end else begin
         {nxt_hi, nxt_lo} = {1'b0, cur_hi, cur_lo[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_q   <= '0;
         lo_q   <= '0;
         b_q    <= '0;
         div_q  <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         done_q <= 1'b0;
         if (start || busy_q) begin
            hi_q <= nxt_hi;
            lo_q <= nxt_lo;
            if (start) begin
               b_q    <= b;
               div_q  <= is_div;
               cnt_q  <= CNT_W'(1);
               busy_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
         end
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops, iterative MULU/DIVU,
// valid/ready handshake on both sides with results held until taken.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic      clk,
   input  logic      rst,
   seq_alu_if.slave  bus
);
   localparam int unsigned SH_W = $clog2(WIDTH);

   state_t           state_q;
   logic [ZC_W-1:0]  zc_q;
   logic             valid_q, zero_q, dz_q;
   logic [WIDTH-1:0] out_q, hi_q;

   logic             accept_c, start_c, is_div_c, dz_c;
   logic [WIDTH-1:0] res_lo_c, res_hi_c;
   logic [SH_W-1:0]  shamt_c;
   logic             md_busy, md_done;
   logic [WIDTH-1:0] md_hi, md_lo;

   function automatic logic flag_eval(input logic [WIDTH-1:0] r, input logic [ZC_W-1:0] zc);
      case (zc)
         ZC_EQ:   return r == '0;
         ZC_NE:   return r != '0;
         ZC_GT:   return !r[WIDTH-1] && (r != '0);
         default: return !r[WIDTH-1];
      endcase
   endfunction

   // Single-cycle result path, including the divide-by-zero shortcut
   always_comb begin
      res_lo_c = '0;
      res_hi_c = '0;
      dz_c     = 1'b0;
      shamt_c  = bus.alu_b[SH_W-1:0];
      case (bus.alu_op)
         OP_AND:  res_lo_c = bus.alu_a & bus.alu_b;
         OP_OR:   res_lo_c = bus.alu_a | bus.alu_b;
         OP_ADD:  res_lo_c = bus.alu_a + bus.alu_b;
         OP_SLT:  res_lo_c = WIDTH'($signed(bus.alu_a) < $signed(bus.alu_b));
         OP_SLL:  res_lo_c = bus.alu_a << shamt_c;
         OP_SRL:  res_lo_c = bus.alu_a >> shamt_c;
         OP_SUB:  res_lo_c = bus.alu_a - bus.alu_b;
         OP_XOR:  res_lo_c = bus.alu_a ^ bus.alu_b;
         OP_NOR:  res_lo_c = ~(bus.alu_a | bus.alu_b);
         OP_SRA:  res_lo_c = WIDTH'($signed(bus.alu_a) >>> shamt_c);
         OP_FSUB: res_lo_c = bus.alu_b - bus.alu_a;
         OP_DIVU: begin
            if (bus.alu_b == '0) begin
               res_lo_c = '1;
               res_hi_c = bus.alu_a;
               dz_c     = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign bus.in_ready = !md_busy && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
   assign accept_c     = bus.in_valid && bus.in_ready;
   assign is_div_c     = (bus.alu_op == OP_DIVU) && (bus.alu_b != '0);
   assign start_c      = accept_c && ((bus.alu_op == OP_MULU) || is_div_c);

   seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .start  (start_c),
      .is_div (is_div_c),
      .a      (bus.alu_a),
      .b      (bus.alu_b),
      .busy   (md_busy),
      .done   (md_done),
      .hi     (md_hi),
      .lo     (md_lo)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         zc_q    <= '0;
         valid_q <= 1'b0;
         out_q   <= '0;
         hi_q    <= '0;
         zero_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start_c) begin
                  state_q <= CALC;
                  zc_q    <= bus.zero_ctr;
                  valid_q <= 1'b0;
               end else if (accept_c) begin
                  state_q <= DONE;
                  valid_q <= 1'b1;
                  out_q   <= res_lo_c;
                  hi_q    <= res_hi_c;
                  zero_q  <= flag_eval(res_lo_c, bus.zero_ctr);
                  dz_q    <= dz_c;
               end else if ((state_q == DONE) && bus.out_ready) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
               end
            end
            CALC: begin
               if (md_done) begin
                  state_q <= DONE;
                  valid_q <= 1'b1;
                  out_q   <= md_lo;
                  hi_q    <= md_hi;
                  zero_q  <= flag_eval(md_lo, zc_q);
                  dz_q    <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.alu_out   = out_q;
   assign bus.alu_hi    = hi_q;
   assign bus.zero      = zero_q;
   assign bus.div_zero  = dz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu with a transaction-level reference model checked every cycle.
module tb_seq_alu;
   localparam int unsigned WIDTH = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seq_alu_if #(.WIDTH(WIDTH)) bus ();
   seq_alu #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain arithmetic on whole operands, plus latency in cycles
   function automatic void alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [1:0] zc, output logic [31:0] o, output logic [31:0] h,
                                     output logic z, output logic dz, output int lat);
      logic [63:0] p;
      int unsigned sh;
      int s;
      sh = b % 32;
      o = 0; h = 0; dz = 0; lat = 1;
      case (op)
         4'd0:  o = a & b;
         4'd1:  o = a | b;
         4'd2:  o = a + b;
         4'd3:  o = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd4:  o = a << sh;
         4'd5:  o = a >> sh;
         4'd6:  o = a - b;
         4'd7:  o = a ^ b;
         4'd8:  begin p = 64'(a) * 64'(b); o = p[31:0]; h = p[63:32]; lat = 33; end
         4'd9:  begin
            if (b == 0) begin o = 32'hFFFF_FFFF; h = a; dz = 1; end
            else begin o = a / b; h = a % b; lat = 33; end
         end
         4'd12: o = ~(a | b);
         4'd13: o = 32'($signed(a) >>> sh);
         4'd14: o = b - a;
         default: ;
      endcase
      s = $signed(o);
      case (zc)
         2'd0: z = (s == 0);
         2'd1: z = (s != 0);
         2'd2: z = (s > 0);
         default: z = (s >= 0);
      endcase
   endfunction

   logic        m_valid = 0, m_busy = 0, m_zero = 0, m_dz = 0;
   logic        p_zero = 0, p_dz = 0;
   logic [31:0] m_out = 0, m_hi = 0, p_out = 0, p_hi = 0;
   int          m_cnt = 0;

   function automatic logic model_ready();
      return (!m_busy && !m_valid) || (m_valid && bus.out_ready);
   endfunction

   always @(posedge clk) begin
      logic [31:0] o, h;
      logic z, dz;
      int lat;
      if (rst) begin
         m_valid = 0; m_busy = 0; m_cnt = 0;
         m_out = 0; m_hi = 0; m_zero = 0; m_dz = 0;
      end else if (m_busy) begin
         m_cnt--;
         if (m_cnt == 0) begin
            m_busy = 0; m_valid = 1;
            m_out = p_out; m_hi = p_hi; m_zero = p_zero; m_dz = p_dz;
         end
      end else if (bus.in_valid && model_ready()) begin
         alu_model(bus.alu_op, bus.alu_a, bus.alu_b, bus.zero_ctr, o, h, z, dz, lat);
         if (lat > 1) begin
            m_busy = 1; m_cnt = lat - 1; m_valid = 0;
            p_out = o; p_hi = h; p_zero = z; p_dz = dz;
         end else begin
            m_valid = 1; m_out = o; m_hi = h; m_zero = z; m_dz = dz;
         end
      end else if (m_valid && bus.out_ready) begin
         m_valid = 0;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("model in_ready", bus.in_ready, model_ready());
         chk("model out_valid", bus.out_valid, m_valid);
         if (m_valid) begin
            chk("model alu_out", bus.alu_out, m_out);
            chk("model alu_hi", bus.alu_hi, m_hi);
            chk("model zero", bus.zero, m_zero);
            chk("model div_zero", bus.div_zero, m_dz);
         end
      end
   end

   // Issue one request, scramble inputs after acceptance, check latency and literal results
   task automatic do_op(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] zc, input logic [31:0] eo, input logic [31:0] eh,
                        input logic ez, input logic edz, input int elat);
      int lat;
      bus.alu_op = op; bus.alu_a = a; bus.alu_b = b; bus.zero_ctr = zc; bus.in_valid = 1;
      @(posedge clk); #1;
      bus.in_valid = 0; bus.alu_a = ~a; bus.alu_b = ~b; bus.alu_op = 4'hF; bus.zero_ctr = ~zc;
      lat = 1;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({nm, " latency"}, 64'(lat), 64'(elat));
      chk({nm, " alu_out"}, bus.alu_out, eo);
      chk({nm, " alu_hi"}, bus.alu_hi, eh);
      chk({nm, " zero"}, bus.zero, ez);
      chk({nm, " div_zero"}, bus.div_zero, edz);
      @(posedge clk); #1;
   endtask

   initial begin
      bus.in_valid = 0; bus.out_ready = 1;
      bus.alu_a = 0; bus.alu_b = 0; bus.alu_op = 0; bus.zero_ctr = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      chk("reset in_ready", bus.in_ready, 1);
      chk("reset out_valid", bus.out_valid, 0);
      chk("reset alu_out", bus.alu_out, 0);
      chk("reset alu_hi", bus.alu_hi, 0);
      chk("reset zero", bus.zero, 0);
      chk("reset div_zero", bus.div_zero, 0);

      do_op("add",     4'b0010, 32'd7, 32'hFFFF_FFFD, 2'b10, 32'd4, 0, 1, 0, 1);
      do_op("mulu",    4'b1000, 32'hFFFF_FFFF, 32'd2, 2'b00, 32'hFFFF_FFFE, 32'd1, 0, 0, 33);
      do_op("divu",    4'b1001, 32'd100, 32'd7, 2'b00, 32'd14, 32'd2, 0, 0, 33);
      do_op("divu0",   4'b1001, 32'd5, 32'd0, 2'b11, 32'hFFFF_FFFF, 32'd5, 0, 1, 1);
      do_op("sra",     4'b1101, 32'h8000_0000, 32'h21, 2'b01, 32'hC000_0000, 0, 1, 0, 1);
      do_op("badop",   4'b1111, 32'd123, 32'd456, 2'b00, 0, 0, 1, 0, 1);
      do_op("slt",     4'b0011, 32'hFFFF_FFFF, 32'd1, 2'b10, 32'd1, 0, 1, 0, 1);
      do_op("sll",     4'b0100, 32'd1, 32'd31, 2'b10, 32'h8000_0000, 0, 0, 0, 1);
      do_op("sllwrap", 4'b0100, 32'd3, 32'h22, 2'b00, 32'd12, 0, 0, 0, 1);
      do_op("srl",     4'b0101, 32'h8000_0000, 32'd4, 2'b00, 32'h0800_0000, 0, 0, 0, 1);
      do_op("sub",     4'b0110, 32'd3, 32'd5, 2'b11, 32'hFFFF_FFFE, 0, 0, 0, 1);
      do_op("fsub",    4'b1110, 32'd3, 32'd5, 2'b01, 32'd2, 0, 1, 0, 1);
      do_op("nor",     4'b1100, 32'd0, 32'd0, 2'b00, 32'hFFFF_FFFF, 0, 0, 0, 1);
      do_op("xor",     4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'b10, 32'h0FF0_0FF0, 0, 1, 0, 1);
      do_op("and",     4'b0000, 32'h0000_FF00, 32'h0000_0F0F, 2'b00, 32'h0000_0F00, 0, 0, 0, 1);
      do_op("or",      4'b0001, 32'h0000_00F0, 32'h0000_000F, 2'b11, 32'h0000_00FF, 0, 1, 0, 1);
      do_op("mulu2",   4'b1000, 32'h1234_5678, 32'h10, 2'b10, 32'h2345_6780, 32'd1, 1, 0, 33);
      do_op("mulu0",   4'b1000, 32'd0, 32'd5, 2'b00, 0, 0, 1, 0, 33);
      do_op("divu2",   4'b1001, 32'hFFFF_FFFF, 32'h10, 2'b01, 32'h0FFF_FFFF, 32'hF, 1, 0, 33);
      do_op("divu3",   4'b1001, 32'd7, 32'd9, 2'b00, 0, 32'd7, 1, 0, 33);

      // Back-pressure: result held, then a new request accepted while it is taken
      bus.out_ready = 0;
      bus.alu_op = 4'b0010; bus.alu_a = 32'd2; bus.alu_b = 32'd3; bus.zero_ctr = 2'b00; bus.in_valid = 1;
      @(posedge clk); #1;
      bus.in_valid = 0;
      chk("hold first valid", bus.out_valid, 1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("hold out_valid", bus.out_valid, 1);
         chk("hold alu_out", bus.alu_out, 32'd5);
         chk("hold zero", bus.zero, 0);
         chk("hold in_ready", bus.in_ready, 0);
      end
      bus.alu_op = 4'b0110; bus.alu_a = 32'd9; bus.alu_b = 32'd9; bus.zero_ctr = 2'b00;
      bus.in_valid = 1; bus.out_ready = 1;
      #1 chk("chain in_ready", bus.in_ready, 1);
      @(posedge clk); #1;
      bus.in_valid = 0;
      chk("chain out_valid", bus.out_valid, 1);
      chk("chain alu_out", bus.alu_out, 0);
      chk("chain zero", bus.zero, 1);
      @(posedge clk); #1;

      // Reset mid-multiply; requests during the multiply must be ignored
      bus.alu_op = 4'b1000; bus.alu_a = 32'hFFFF_FFFF; bus.alu_b = 32'd3; bus.zero_ctr = 2'b00;
      bus.in_valid = 1;
      @(posedge clk); #1;
      bus.alu_op = 4'b0010; bus.alu_a = 32'd1; bus.alu_b = 32'd1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("calc in_ready", bus.in_ready, 0);
      end
      bus.in_valid = 0;
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      chk("rst out_valid", bus.out_valid, 0);
      chk("rst alu_out", bus.alu_out, 0);
      chk("rst alu_hi", bus.alu_hi, 0);
      chk("rst zero", bus.zero, 0);
      chk("rst div_zero", bus.div_zero, 0);
      chk("rst in_ready", bus.in_ready, 1);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         chk("abandoned result", bus.out_valid, 0);
      end
      do_op("post-rst add", 4'b0010, 32'd1, 32'd1, 2'b00, 32'd2, 0, 0, 0, 1);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
      $fatal(1);
   end

endmodule
